// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                             |
// | Shared types, widths and length helper for the fetch sequencer.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int c_ADDR_WIDTH     = 32;
  localparam int c_DATA_BUS_WIDTH = 48;
  localparam int c_LEN_WIDTH      = 2;

  typedef enum logic [1:0] {
    START = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  typedef enum logic [c_LEN_WIDTH-1:0] {
    NONE = 2'd0,
    L16  = 2'd1,
    L32  = 2'd2,
    L48  = 2'd3
  } instr_len_t;

  function automatic logic [2:0] len_bytes(input instr_len_t len);
    case (len)
      L16:     return 3'd2;
      L32:     return 3'd4;
      L48:     return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer_if                                                    |
// | RAM read port, redirect input and decoder handshake of the fetcher.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH     = c_ADDR_WIDTH,
  parameter int DATA_BUS_WIDTH = c_DATA_BUS_WIDTH
);

  logic                      mem_enable;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_BUS_WIDTH-1:0] mem_data;
  logic                      redirect_valid;
  logic [ADDR_WIDTH-1:0]     redirect_pc;
  logic                      instr_valid;
  logic                      instr_ready;
  logic [DATA_BUS_WIDTH-1:0] instr_data;
  logic [c_LEN_WIDTH-1:0]    instr_len;
  logic [ADDR_WIDTH-1:0]     instr_pc;

  modport master (
    output mem_enable, mem_addr,
    input  mem_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_len, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_enable, mem_addr,
    output mem_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_len, instr_pc,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_len_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_len_decode                                                      |
// | Decodes instruction length from byte0 and zeroes the unused bytes.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_len_decode
  import fetch_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = c_DATA_BUS_WIDTH
) (
  input  wire logic [DATA_BUS_WIDTH-1:0] i_window,
  output instr_len_t                     o_len,
  output logic [DATA_BUS_WIDTH-1:0]      o_data
);

  logic [7:0]                w_byte0;
  logic [DATA_BUS_WIDTH-1:0] w_mask;

  assign w_byte0 = i_window[DATA_BUS_WIDTH-1 -: 8];

  // The two top bits of byte0 select the length; anything not 1x is 16-bit.
  always_comb begin
    o_len  = L16;
    w_mask = {DATA_BUS_WIDTH{1'b1}} << (DATA_BUS_WIDTH - 16);
    case (w_byte0[7:6])
      2'b11: begin
        o_len  = L48;
        w_mask = {DATA_BUS_WIDTH{1'b1}};
      end
      2'b10: begin
        o_len  = L32;
        w_mask = {DATA_BUS_WIDTH{1'b1}} << (DATA_BUS_WIDTH - 32);
      end
      default: begin
        o_len  = L16;
        w_mask = {DATA_BUS_WIDTH{1'b1}} << (DATA_BUS_WIDTH - 16);
      end
    endcase
  end

  assign o_data = i_window & w_mask;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer                                                       |
// | One RAM read per instruction, presented over valid/ready; redirects.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = c_ADDR_WIDTH,
  parameter int                    DATA_BUS_WIDTH = c_DATA_BUS_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input wire logic           clk,
  input wire logic           rst,
  fetch_sequencer_if.master  bus
);

  fetch_state_t              r_state;
  fetch_state_t              w_state_next;
  logic [ADDR_WIDTH-1:0]     r_pc;
  logic [ADDR_WIDTH-1:0]     w_pc_next;
  logic [ADDR_WIDTH-1:0]     w_pc_step;
  logic [ADDR_WIDTH-1:0]     w_redirect_target;
  logic                      w_capture;
  logic                      w_clear;

  logic                      r_instr_valid;
  logic [DATA_BUS_WIDTH-1:0] r_instr_data;
  instr_len_t                r_instr_len;
  logic [ADDR_WIDTH-1:0]     r_instr_pc;

  instr_len_t                w_dec_len;
  logic [DATA_BUS_WIDTH-1:0] w_dec_data;

  fetch_len_decode #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH)
  ) u_len_decode (
    .i_window (bus.mem_data),
    .o_len    (w_dec_len),
    .o_data   (w_dec_data)
  );

  assign w_pc_step         = {{(ADDR_WIDTH-3){1'b0}}, len_bytes(r_instr_len)};
  assign w_redirect_target = bus.redirect_pc & ~{{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= START;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      START: w_state_next = ISSUE;
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        w_capture    = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        if (r_instr_valid && bus.instr_ready) begin
          w_pc_next    = r_pc + w_pc_step;
          w_clear      = 1'b1;
          w_state_next = ISSUE;
        end
      end
      default: w_state_next = START;
    endcase
    // A redirect overrides everything after START, including a same-cycle handshake.
    if (r_state != START && bus.redirect_valid) begin
      w_pc_next    = w_redirect_target;
      w_capture    = 1'b0;
      w_clear      = 1'b1;
      w_state_next = ISSUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_instr_len   <= NONE;
      r_instr_pc    <= '0;
    end else if (w_clear) begin
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_instr_len   <= NONE;
      r_instr_pc    <= '0;
    end else if (w_capture) begin
      r_instr_valid <= 1'b1;
      r_instr_data  <= w_dec_data;
      r_instr_len   <= w_dec_len;
      r_instr_pc    <= r_pc;
    end
  end

  assign bus.mem_enable  = (r_state == ISSUE);
  assign bus.mem_addr    = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr_data  = r_instr_data;
  assign bus.instr_len   = r_instr_len;
  assign bus.instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer                                                    |
// | Byte RAM model plus transaction-level reference for fetch_sequencer.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_WIDTH(32), .DATA_BUS_WIDTH(48)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH     (32),
    .DATA_BUS_WIDTH (48),
    .RESET_PC       (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [0:255];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [47:0] window(input logic [31:0] a);
    logic [47:0] w;
    logic [31:0] ai;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      ai = a + 32'(i);
      w  = {w[39:0], ram[ai[7:0]]};
    end
    return w;
  endfunction

  function automatic int exp_len(input logic [31:0] a);
    logic [7:0] b0;
    b0 = ram[a[7:0]];
    if (b0 >= 8'hC0) return 3;
    else if (b0 >= 8'h80) return 2;
    else return 1;
  endfunction

  function automatic logic [47:0] exp_data(input logic [31:0] a);
    logic [63:0] low;
    low = (64'h1 << (48 - 16 * exp_len(a))) - 64'h1;
    return window(a) & ~low[47:0];
  endfunction

  // Registered-read test RAM.
  always @(posedge clk) begin
    if (bus.mem_enable) bus.mem_data <= window(bus.mem_addr);
  end

  // Reference: m_pc is the fetch address, m_t counts edges since the fetch was kicked off.
  bit          m_started = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  int          m_t       = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1'b0;
      m_pc      = 32'h0;
      m_t       = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      m_t       = 0;
    end else if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc & 32'hFFFF_FFFE;
      m_t  = 0;
    end else if (m_t >= 2 && bus.instr_ready) begin
      m_pc = m_pc + 32'(2 * exp_len(m_pc));
      m_t  = 0;
    end else if (m_t < 2) begin
      m_t = m_t + 1;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic        e_en, e_valid;
    logic [47:0] e_data;
    logic [1:0]  e_len;
    logic [31:0] e_pc;
    e_en = 1'b0; e_valid = 1'b0; e_data = '0; e_len = 2'd0; e_pc = '0;
    if (m_started) begin
      if (m_t == 0) e_en = 1'b1;
      if (m_t >= 2) begin
        e_valid = 1'b1;
        e_data  = exp_data(m_pc);
        e_len   = 2'(exp_len(m_pc));
        e_pc    = m_pc;
      end
    end
    check_value("mem_enable",  64'(bus.mem_enable),  64'(e_en));
    check_value("mem_addr",    64'(bus.mem_addr),    64'(m_pc));
    check_value("instr_valid", 64'(bus.instr_valid), 64'(e_valid));
    check_value("instr_data",  64'(bus.instr_data),  64'(e_data));
    check_value("instr_len",   64'(bus.instr_len),   64'(e_len));
    check_value("instr_pc",    64'(bus.instr_pc),    64'(e_pc));
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    check_cycle();
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic do_reset(input logic rdy, input logic rv, input logic [31:0] rpc);
    rst = 1'b1;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    rst = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  endtask

  initial begin
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_data       = '0;
    clear_ram();

    // Reset release and a 16-bit fetch held for five cycles.
    for (int i = 0; i < 6; i++) ram[i] = 8'(8'h11 * (i + 1));
    do_reset(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("first_issue_addr", 64'(bus.mem_addr), 64'h0);
    check_value("first_issue_en",   64'(bus.mem_enable), 64'h1);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("first_data", 64'(bus.instr_data), 64'h1122_0000_0000);
    check_value("first_len",  64'(bus.instr_len), 64'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check_value("hold_pc", 64'(bus.instr_pc), 64'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("after_hs_addr", 64'(bus.mem_addr), 64'h2);

    // 32-bit then 48-bit back to back.
    clear_ram();
    ram[0] = 8'h80;
    ram[4] = 8'hC0;
    do_reset(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check_value("seq_len0", 64'(bus.instr_len), 64'h2);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check_value("seq_pc1",  64'(bus.instr_pc), 64'h4);
    check_value("seq_len1", 64'(bus.instr_len), 64'h3);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("seq_next_addr", 64'(bus.mem_addr), 64'hA);

    // Redirect while the read is in flight.
    clear_ram();
    do_reset(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h41);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("redir_addr", 64'(bus.mem_addr), 64'h40);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("redir_valid_pc", 64'(bus.instr_pc), 64'h40);

    // Redirect coinciding with a handshake.
    do_reset(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h20);
    check_value("hsredir_pc", 64'(bus.instr_pc), 64'h8);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("hsredir_addr", 64'(bus.mem_addr), 64'h20);

    // PC wrap, then reset during WAIT.
    clear_ram();
    ram[8'hFE] = 8'h80;
    do_reset(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check_value("wrap_len", 64'(bus.instr_len), 64'h2);
    cycle(1'b0, 1'b0, 32'h0);
    check_value("wrap_addr", 64'(bus.mem_addr), 64'h2);
    cycle(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check_value("rst_mem_enable",  64'(bus.mem_enable), 64'h0);
    check_value("rst_mem_addr",    64'(bus.mem_addr), 64'h0);
    check_value("rst_instr_valid", 64'(bus.instr_valid), 64'h0);
    check_value("rst_instr_data",  64'(bus.instr_data), 64'h0);
    check_value("rst_instr_len",   64'(bus.instr_len), 64'h0);
    check_value("rst_instr_pc",    64'(bus.instr_pc), 64'h0);

    // Random traffic; a redirect during START must be ignored.
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    do_reset(1'b1, 1'b1, 32'h80);
    for (int c = 0; c < 1500; c++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), $urandom);
    end
    cycle(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetches from the byte-addressed test RAM (32-bit address, 48-bit big-endian read window, one-cycle registered read latency). Issues one read per instruction, decodes instruction length (16/32/48 bits) from the first byte, presents the left-justified instruction to the decoder over a valid/ready handshake, and advances the PC by the decoded length. Sits between the test RAM and the instruction decoder in the simulation top level; accepts branch redirects from downstream.

## Interface
- `ADDR_WIDTH`, 32, PC / RAM address width
- `DATA_BUS_WIDTH`, 48, RAM read window width (6 bytes)
- `RESET_PC`, 32'h0, PC loaded on reset
- `clk` in 1: single clock.
- `rst` in 1: asynchronous reset, active-high.
- `mem_enable` out 1: RAM read enable.
- `mem_addr` out ADDR_WIDTH: RAM byte address.
- `mem_data` in DATA_BUS_WIDTH: RAM read data; bits [47:40] hold byte at `mem_addr`.
- `redirect_valid` in 1: load new PC, flush.
- `redirect_pc` in ADDR_WIDTH: redirect target.
- `instr_valid` out 1: instruction available.
- `instr_ready` in 1: decoder accepts.
- `instr_data` out DATA_BUS_WIDTH: instruction, left-justified, unused low bytes zero.
- `instr_len` out 2: 1 = 16-bit, 2 = 32-bit, 3 = 48-bit, 0 = none.
- `instr_pc` out ADDR_WIDTH: address of presented instruction.

## Operation
- States: START, ISSUE, WAIT, HOLD.
- START: outputs idle; next ISSUE.
- ISSUE: `mem_enable`=1, `mem_addr`=pc; next WAIT.
- WAIT: `mem_data` valid; capture `instr_data`, `instr_len`, `instr_pc`=pc; set `instr_valid`; next HOLD.
- HOLD: hold outputs stable while `instr_valid && !instr_ready`. On handshake: pc += 2·`instr_len` bytes (mod 2^32), clear `instr_valid`, next ISSUE.
- Length decode on byte0 = `mem_data[47:40]`: byte0[7:6]=2'b11 → 48-bit; 2'b10 → 32-bit; otherwise 16-bit.
- Masking: 16-bit zeroes `instr_data[31:0]`; 32-bit zeroes `[15:0]`; 48-bit passes all.
- `mem_enable`, `mem_addr` decode combinationally from state/pc; `mem_addr` = pc in all states.
- Redirect: `redirect_valid` has priority in every state except START. Next cycle: pc = `redirect_pc` with bit 0 forced to 0, `instr_valid`=0, state ISSUE. An in-flight read (WAIT) is discarded.
- Redirect in the same cycle as a handshake: the instruction counts as consumed; pc takes the redirect target, not pc+len.
- In START, `redirect_valid` is ignored.
- PC wraps modulo 2^32; RAM-side wrap is the RAM's concern.

## Timing
- Reset values: state START, pc=`RESET_PC`, `instr_valid`=0, `instr_data`=0, `instr_len`=0, `instr_pc`=0; `mem_enable`=0.
- Reset mid-operation clears everything immediately; an in-flight read is dropped.
- The first ISSUE occurs the cycle after reset deasserts. `instr_valid` rises 2 cycles after entering ISSUE.
- With `instr_ready` held high, throughput is 1 instruction per 3 cycles: ISSUE, WAIT, HOLD.
- Redirect to first `instr_valid` of the target: 3 cycles (redirect cycle, ISSUE, WAIT).
- `instr_*` outputs are registered and change only on the WAIT→HOLD edge, or clear on handshake, redirect or reset.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t`;
  - length enum `instr_len_t` (NONE/L16/L32/L48);
  - width constants;
  - function returning byte count of an `instr_len_t`.
- Sub-module `fetch_len_decode`: combinational byte0 → `instr_len_t` plus data masking.
- The bench instantiates `fetch_sequencer` with the existing test RAM.

## Test plan
- Reset release with RESET_PC=0 and RAM[0..5]=11 22 33 44 55 66 → `mem_addr`=0 in cycle 1; `instr_valid` in cycle 3 with data 48'h112200000000, len=1, pc=0.
- RAM[0]=8'h80, RAM[4]=8'hC0, `instr_ready` held 1 → pcs 0 then 4, lens 2 then 3; next fetch at address 10; one instruction per 3 cycles.
- Hold `instr_ready`=0 for 5 cycles in HOLD → `instr_data`/`instr_len`/`instr_pc` unchanged, `mem_enable` stays 0; handshake on cycle 6 → ISSUE next.
- `redirect_valid` with `redirect_pc`=32'h41 during WAIT → fetched data discarded, next `mem_addr`=32'h40, first valid pc=32'h40.
- Redirect coincident with handshake at pc=8 (len 16-bit), target 32'h20 → next `mem_addr`=32'h20, not 10.
- pc=32'hFFFFFFFE with a 32-bit instruction accepted → next pc=32'h2; assert `rst` during WAIT → all outputs return to reset values in the same cycle.
